// File: rtl/cpu_defs.sv
// Shared definitions for the instruction fetch path: widths, NOP encoding,
// reset PC, fetch FSM state and the {pc, instr} queue entry.
package cpu_defs;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between instruction memory and the core.
// Flush empties the queue and takes precedence over a same-cycle push or pop.
module fetch_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetch stage: fetches sequential words from instruction memory into a small
// queue and feeds the core, inserting NOPs when empty and restarting on redirect.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  output logic [31:0]  i_datain,
  output logic [31:0]  i_pc,
  output logic         i_valid,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output fetch_state_e dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [CW-1:0] ROOM_LIMIT = CW'(DEPTH - 1);

  // Handshake: imem_req and imem_addr are registered. A request is outstanding from
  // the cycle imem_req is high until the cycle imem_ack is sampled high; both hold
  // steady for that whole span, even across redirects. At most one is outstanding.

  fetch_state_e  state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic          req_n;
  logic [31:0]   addr_n;
  logic [31:0]   redir_pc;
  logic [31:0]   drop_target;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign redir_pc    = redirect_pc & ~32'd3;
  assign drop_target = redirect_valid ? redir_pc : fetch_pc;
  assign push_entry  = '{pc: fetch_pc, instr: imem_rdata};
  assign i_valid     = (count != '0);
  assign pop         = i_valid && !stall && !redirect_valid;
  assign i_datain    = i_valid ? head.instr : NOP_INSTR;
  assign i_pc        = i_valid ? head.pc : 32'h0;
  assign dbg_state   = state;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_n      = imem_req;
    addr_n     = imem_addr;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_n = redir_pc;
        end else if (count < FULL) begin
          req_n   = 1'b1;
          addr_n  = fetch_pc;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack && redirect_valid) begin
          fetch_pc_n = redir_pc;
          req_n      = 1'b1;
          addr_n     = redir_pc;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_n = fetch_pc + 32'd4;
          // Room is judged with the word being pushed now already counted.
          if (count < ROOM_LIMIT) begin
            req_n  = 1'b1;
            addr_n = fetch_pc + 32'd4;
          end else begin
            req_n   = 1'b0;
            state_n = IDLE;
          end
        end else if (redirect_valid) begin
          fetch_pc_n = redir_pc;
          state_n    = DROP;
        end
      end
      DROP: begin
        fetch_pc_n = drop_target;
        if (imem_ack) begin
          req_n   = 1'b1;
          addr_n  = drop_target;
          state_n = WAIT;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, back-pressure, redirects
// (mid-wait, same-cycle ack, full queue), PC wrap and asynchronous reset mid-request.
module tb_instr_fetch_unit;
  import cpu_defs::*;

  localparam logic [31:0] DMASK = 32'hDEAD_0000;

  logic         clock;
  logic         reset;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         stall;
  logic [31:0]  i_datain;
  logic [31:0]  i_pc;
  logic         i_valid;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  fetch_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .i_datain       (i_datain),
    .i_pc           (i_pc),
    .i_valid        (i_valid),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: the word at address A reads as A ^ DMASK.
  assign imem_rdata = imem_addr ^ DMASK;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_ack       = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_ack       = 1'b0;

    // 1. Reset state, then back-to-back fetch with ack every cycle.
    apply_reset();
    check("rst_req",   32'(imem_req),  32'h0);
    check("rst_addr",  imem_addr,      32'h0);
    check("rst_valid", 32'(i_valid),   32'h0);
    check("rst_data",  i_datain,       32'h0);
    check("rst_pc",    i_pc,           32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    imem_ack = 1'b1;
    tick();
    check("t1_req0",   32'(imem_req),  32'h1);
    check("t1_addr0",  imem_addr,      32'h0);
    check("t1_valid0", 32'(i_valid),   32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_addr",  imem_addr,    32'(4 * (i + 1)));
      check("t1_valid", 32'(i_valid), 32'h1);
      check("t1_pc",    i_pc,         32'(4 * i));
      check("t1_data",  i_datain,     32'(4 * i) ^ DMASK);
    end

    // 2. Stall held: queue fills to 4, then requests stop; release drains in order.
    apply_reset();
    stall    = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t2_req_full", 32'(imem_req), 32'h1);
    tick();
    check("t2_req_off", 32'(imem_req),  32'h0);
    check("t2_idle",    32'(dbg_state), 32'(IDLE));
    tick();
    tick();
    check("t2_req_off2", 32'(imem_req), 32'h0);
    check("t2_head",     i_pc,          32'h0);
    check("t2_valid",    32'(i_valid),  32'h1);
    stall = 1'b0;
    tick();
    check("t2_pop4",  i_pc,          32'h4);
    check("t2_req_a", 32'(imem_req), 32'h0);
    tick();
    check("t2_pop8",   i_pc,          32'h8);
    check("t2_req_b",  32'(imem_req), 32'h1);
    check("t2_resume", imem_addr,     32'h10);
    tick();
    check("t2_popc", i_pc, 32'hC);
    tick();
    check("t2_pop10",   i_pc,     32'h10);
    check("t2_data10",  i_datain, 32'h10 ^ DMASK);

    // 3. Redirect to 0x103 while the request to 0 waits; ack arrives 3 cycles later.
    apply_reset();
    tick();
    check("t3_addr0", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    check("t3_hold_a",  imem_addr,      32'h0);
    check("t3_req_a",   32'(imem_req),  32'h1);
    check("t3_drop",    32'(dbg_state), 32'(DROP));
    check("t3_valid_a", 32'(i_valid),   32'h0);
    tick();
    check("t3_hold_b", imem_addr, 32'h0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("t3_addr100", imem_addr,    32'h100);
    check("t3_valid_b", 32'(i_valid), 32'h0);
    tick();
    check("t3_valid_c", 32'(i_valid), 32'h0);
    check("t3_hold_c",  imem_addr,    32'h100);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("t3_valid_d", 32'(i_valid), 32'h1);
    check("t3_pc100",   i_pc,         32'h100);
    check("t3_data100", i_datain,     32'h100 ^ DMASK);

    // 4. Redirect with ack in the same WAIT cycle, then redirect on a full queue.
    apply_reset();
    tick();
    imem_ack       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("t4_nopush", 32'(i_valid), 32'h0);
    check("t4_addr40", imem_addr,    32'h40);
    check("t4_req",    32'(imem_req), 32'h1);
    tick();
    check("t4_pc40", i_pc, 32'h40);
    stall = 1'b1;
    tick();
    tick();
    tick();
    check("t4_full_req", 32'(imem_req), 32'h0);
    check("t4_full_pc",  i_pc,          32'h40);
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("t4_flush_valid", 32'(i_valid), 32'h0);
    check("t4_flush_data",  i_datain,     32'h0);
    check("t4_flush_pc",    i_pc,         32'h0);
    tick();
    check("t4_req80",  32'(imem_req), 32'h1);
    check("t4_addr80", imem_addr,     32'h80);

    // 5. Redirect to the top of the address space; fetch wraps to 0.
    apply_reset();
    imem_ack = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("t5_addr_wrap", imem_addr, 32'h0);
    check("t5_pc_top",    i_pc,      32'hFFFF_FFFC);
    tick();
    check("t5_addr4", imem_addr, 32'h4);
    check("t5_pc0",   i_pc,      32'h0);

    // 6. Asynchronous reset while a request is outstanding; a later ack is ignored.
    apply_reset();
    tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    check("t6_pre_req",  32'(imem_req), 32'h1);
    check("t6_pre_addr", imem_addr,     32'h4);
    reset = 1'b1;
    #1;
    check("t6_async_req",   32'(imem_req), 32'h0);
    check("t6_async_valid", 32'(i_valid),  32'h0);
    check("t6_async_addr",  imem_addr,     32'h0);
    #1;
    reset    = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("t6_ign_valid", 32'(i_valid),  32'h0);
    check("t6_new_req",   32'(imem_req), 32'h1);
    check("t6_new_addr",  imem_addr,     32'h0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
